shift_add_mult: RTL and testbench
=================================

Name: shift_add_mult

Overview:
- Sequential radix-2 shift-and-add multiplier.
- Computes the full 2*WIDTH-bit product of two WIDTH-bit operands, signed or unsigned, selected per operation.
- Companion to the sequential divider in the arithmetic datapath.
- Fixed latency: one multiplier bit per clock.
- Start/busy/ready handshake.

Parameters:
WIDTH, 32, operand width in bits; product is 2*WIDTH bits; legal range 2..64

Ports:
clk  input  1  system clock; all state updates on rising edge
reset  input  1  synchronous, active-low reset; sampled on rising edge of clk
start  input  1  request; accepted only in IDLE or DONE
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with start
multiplicand_in  input  WIDTH  operand A; sampled with start
multiplier_in  input  WIDTH  operand B; sampled with start
product_out  output  2*WIDTH  A*B result; valid while ready=1
busy  output  1  high while iterating (RUN state)
ready  output  1  high while a completed result is held (DONE state)

Behaviour:
- Reset (reset=0 at a rising edge):
  - state=IDLE; busy=0; ready=0; product_out=0; internal accumulator, operand registers and counter cleared.
  - Reset overrides start; takes effect mid-operation and abandons the operation.
- All outputs are registered. No combinational path from inputs to outputs.
- States: IDLE, RUN, DONE (3-bit or one-hot encoding).
- IDLE:
  - start=1 -> RUN at the next edge.
  - On that edge:
    - latch magnitudes |A| and |B|. In unsigned mode these are the raw values. In signed mode, negate any operand whose MSB is 1.
    - latch neg_flag = is_signed & (A[MSB] ^ B[MSB]).
    - clear the 2*WIDTH accumulator; count=0.
  - start=0 -> stay in IDLE.
- RUN, each edge:
  - if multiplier LSB=1, add the zero-extended multiplicand into the upper WIDTH+1 bits of the accumulator.
  - shift {carry, accumulator} right by 1; shift the multiplier right by 1; count=count+1.
  - The carry bit is mandatory; no product bits may be lost.
  - After the WIDTH-th RUN edge (count reaches WIDTH): state=DONE.
  - On that same edge, product_out = neg_flag ? two's-complement negation of the accumulator : accumulator.
  - start is ignored throughout RUN; operand inputs may change freely.
- DONE:
  - ready=1 and product_out is held stable.
  - start=1 -> accepted exactly as in IDLE; ready falls at that edge; product_out keeps the old value until the new result is written.
  - start=0 -> remain in DONE indefinitely.
- Latency:
  - start sampled at edge k -> busy=1 after edges k+1 through k+WIDTH-1.
  - ready=1 and product_out valid after edge k+WIDTH.
  - Identical for all operand values, including zero (no early termination).
- Arithmetic:
  - Magnitude of the most negative value (1 followed by WIDTH-1 zeros) is its unsigned bit pattern; the magnitude path is WIDTH bits unsigned, so no overflow.
  - Results always fit in 2*WIDTH bits; no overflow flag.
- busy and ready are mutually exclusive; both are 0 only in IDLE.

Test Plan:
- Reset mid-run:
  - start with A=7, B=9 unsigned; drive reset=0 at cycle 10 of RUN.
  - Next edge: busy=0, ready=0, product_out=0, IDLE.
  - Then a fresh start with A=3, B=5 -> product_out=15 after exactly 32 cycles.
- Unsigned basics and latency (WIDTH=32):
  - A=0x0000FFFF, B=0x0000FFFF -> 0x00000000FFFE0001.
  - A=0xFFFFFFFF, B=0xFFFFFFFF -> 0xFFFFFFFE00000001.
  - Check ready rises exactly 32 edges after the start edge and busy is high for the 31 cycles before that.
- Signed combinations:
  - A=-3, B=7 -> 0xFFFFFFFFFFFFFFEB (-21).
  - A=-3, B=-7 -> 21.
  - A=0x80000000, B=0x80000000 -> 0x4000000000000000.
  - A=0x80000000, B=1 -> 0xFFFFFFFF80000000.
  - Same bit patterns with is_signed=0 -> 0x4000000000000000 and 0x0000000080000000.
- Zero and ignored start:
  - A=0, B=0xDEADBEEF -> 0 after full 32-cycle latency.
  - Pulse start and change operands during RUN -> result unaffected, no restart.
- Back-to-back:
  - In DONE holding 15, assert start with A=2, B=2.
  - ready falls next edge; product_out stays 15 until 32 edges later, then becomes 4.
- Randomized:
  - 1000 random operand pairs, random is_signed, random start gaps.
  - Compare against a reference model; busy/ready never both 1.

Source files
------------

// File: rtl/shift_add_mult.sv
// Sequential radix-2 shift-and-add multiplier: full 2*WIDTH-bit product of two
// WIDTH-bit operands, signed or unsigned, one multiplier bit per clock.
module shift_add_mult #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 is_signed,
    input  logic [WIDTH-1:0]     multiplicand_in,
    input  logic [WIDTH-1:0]     multiplier_in,
    output logic [2*WIDTH-1:0]   product_out,
    output logic                 busy,
    output logic                 ready
);

    localparam int CW = $clog2(WIDTH + 1);

    // One-hot so busy/ready come straight from state flops.
    localparam logic [2:0] S_IDLE = 3'b001;
    localparam logic [2:0] S_RUN  = 3'b010;
    localparam logic [2:0] S_DONE = 3'b100;

    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    logic [2:0]           state_q,   state_d;
    logic [2*WIDTH-1:0]   acc_q,     acc_d;
    logic [WIDTH-1:0]     mcand_q,   mcand_d;
    logic [WIDTH-1:0]     mplier_q,  mplier_d;
    logic                 neg_q,     neg_d;
    logic [CW-1:0]        count_q,   count_d;
    logic [2*WIDTH-1:0]   product_q, product_d;

    logic [WIDTH:0]       partial;
    logic [2*WIDTH:0]     wide;
    logic [2*WIDTH-1:0]   shifted;

    // Upper half plus optional multiplicand keeps its carry in bit WIDTH,
    // which becomes the new accumulator MSB after the right shift.
    assign partial = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    assign wide    = {partial, acc_q[WIDTH-1:0]};
    assign shifted = (2*WIDTH)'(wide >> 1);

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path through
        // the case statement leaves it unassigned, which would infer a latch.
        state_d   = state_q;
        acc_d     = acc_q;
        mcand_d   = mcand_q;
        mplier_d  = mplier_q;
        neg_d     = neg_q;
        count_d   = count_q;
        product_d = product_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d  = S_RUN;
                    mcand_d  = (is_signed && multiplicand_in[WIDTH-1])
                             ? -multiplicand_in : multiplicand_in;
                    mplier_d = (is_signed && multiplier_in[WIDTH-1])
                             ? -multiplier_in : multiplier_in;
                    neg_d    = is_signed & (multiplicand_in[WIDTH-1] ^ multiplier_in[WIDTH-1]);
                    acc_d    = '0;
                    count_d  = '0;
                end
            end
            S_RUN: begin
                acc_d    = shifted;
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
                if (count_q == LAST_COUNT) begin
                    state_d   = S_DONE;
                    product_d = neg_q ? -shifted : shifted;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!reset) begin
            state_q   <= S_IDLE;
            acc_q     <= '0;
            mcand_q   <= '0;
            mplier_q  <= '0;
            neg_q     <= 1'b0;
            count_q   <= '0;
            product_q <= '0;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            mcand_q   <= mcand_d;
            mplier_q  <= mplier_d;
            neg_q     <= neg_d;
            count_q   <= count_d;
            product_q <= product_d;
        end
    end

    assign busy        = state_q[1];
    assign ready       = state_q[2];
    assign product_out = product_q;

endmodule

// File: tb/tb_shift_add_mult.sv
// Scoreboard bench for shift_add_mult: stimulus pushes expected products,
// a negedge monitor pops and compares on each rising ready.
module tb_shift_add_mult;

    localparam int W = 32;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             is_signed;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic [2*W-1:0]   product;
    logic             busy;
    logic             ready;

    always #5 clk = ~clk;

    shift_add_mult #(.WIDTH(W)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .is_signed       (is_signed),
        .multiplicand_in (a),
        .multiplier_in   (b),
        .product_out     (product),
        .busy            (busy),
        .ready           (ready)
    );

    int             n_checks = 0;
    int             n_fails  = 0;
    logic [63:0]    exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%h, expected 0x%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic sg);
        logic signed [63:0] sx;
        logic signed [63:0] sy;
        if (sg) begin
            sx = {{32{x[31]}}, x};
            sy = {{32{y[31]}}, y};
            return sx * sy;
        end
        return {32'b0, x} * {32'b0, y};
    endfunction

    // Monitor: result on rising ready, hold while ready stays high, exclusivity always.
    logic           mon_en     = 1'b0;
    logic           prev_ready = 1'b0;
    logic [63:0]    prev_prod  = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            check("busy_ready_exclusive", 64'(busy & ready), 64'd0);
            if (ready && !prev_ready) begin
                if (exp_q.size() == 0)
                    check("result_expected", 64'(exp_q.size()), 64'd1);
                else
                    check("product", product, exp_q.pop_front());
            end
            if (ready && prev_ready)
                check("product_hold", product, prev_prod);
        end
        prev_ready = ready;
        prev_prod  = product;
    end

    // Drives start for one cycle; returns half a cycle after the accepting edge.
    task automatic issue(input logic [31:0] av, input logic [31:0] bv, input logic sg,
                         input logic [63:0] exp, input logic push);
        @(negedge clk);
        a         = av;
        b         = bv;
        is_signed = sg;
        start     = 1'b1;
        if (push) exp_q.push_back(exp);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic check_latency(input string name);
        for (int i = 1; i < W; i++) begin
            @(negedge clk);
            check({name, "_busy"}, 64'(busy), 64'd1);
            check({name, "_not_ready"}, 64'(ready), 64'd0);
        end
        @(negedge clk);
        check({name, "_ready"}, 64'(ready), 64'd1);
    endtask

    task automatic wait_ready(input int budget);
        int n = 0;
        while (!ready && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("ready_within_budget", 64'(ready), 64'd1);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        logic [31:0] ra, rb;
        logic        rs;

        reset = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_ready", 64'(ready), 64'd0);
        check("reset_product", product, 64'd0);
        reset  = 1'b1;
        mon_en = 1'b1;

        // Abandoned operation: reset during the 10th RUN cycle.
        issue(32'd7, 32'd9, 1'b0, 64'd63, 1'b0);
        repeat (9) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midrun_reset_busy", 64'(busy), 64'd0);
        check("midrun_reset_ready", 64'(ready), 64'd0);
        check("midrun_reset_product", product, 64'd0);
        reset = 1'b1;

        issue(32'd3, 32'd5, 1'b0, 64'd15, 1'b1);
        check_latency("after_reset");

        // Restart from DONE: old result stays visible until the new one lands.
        issue(32'd2, 32'd2, 1'b0, 64'd4, 1'b1);
        check("b2b_ready_falls", 64'(ready), 64'd0);
        check("b2b_old_product", product, 64'd15);
        for (int i = 1; i < W; i++) begin
            @(negedge clk);
            check("b2b_hold_15", product, 64'd15);
        end
        @(negedge clk);
        check("b2b_ready", 64'(ready), 64'd1);

        issue(32'h0000FFFF, 32'h0000FFFF, 1'b0, 64'h00000000FFFE0001, 1'b1);
        check_latency("u_ffff");
        issue(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE00000001, 1'b1);
        check_latency("u_max");
        issue(-32'sd3, 32'd7, 1'b1, 64'hFFFFFFFFFFFFFFEB, 1'b1);
        check_latency("s_m3x7");
        issue(-32'sd3, -32'sd7, 1'b1, 64'd21, 1'b1);
        check_latency("s_m3xm7");
        issue(32'h80000000, 32'h80000000, 1'b1, 64'h4000000000000000, 1'b1);
        check_latency("s_minxmin");
        issue(32'h80000000, 32'h00000001, 1'b1, 64'hFFFFFFFF80000000, 1'b1);
        check_latency("s_minx1");
        issue(32'h80000000, 32'h80000000, 1'b0, 64'h4000000000000000, 1'b1);
        check_latency("u_minxmin");
        issue(32'h80000000, 32'h00000001, 1'b0, 64'h0000000080000000, 1'b1);
        check_latency("u_minx1");

        // Zero operand, plus a start pulse and operand churn mid-run.
        issue(32'd0, 32'hDEADBEEF, 1'b0, 64'd0, 1'b1);
        repeat (4) @(negedge clk);
        a = 32'd12345; b = 32'd777; is_signed = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0; a = 32'hFFFF0000; b = 32'h0000FFFF;
        n = 5;
        while (!ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("ignored_start_latency", 64'(n), 64'd32);

        for (int k = 0; k < 1000; k++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            ra = $urandom;
            rb = $urandom;
            rs = 1'($urandom_range(0, 1));
            issue(ra, rb, rs, model(ra, rb, rs), 1'b1);
            wait_ready(40);
        end

        repeat (3) @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
